sdm_stream_ctrl: RTL

//  Rate scheduler for the sigma-delta DAC/ADC pair. Buffers 16-bit PCM from an upstream

---
 rtl/sdm_stream_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sdm_stream_ctrl.sv
// Sigma-delta rate scheduler: PCM FIFO, modulator/ADC tick generation, per-sample advance.
// Build option SDM_UNDERRUN_HOLD_EN: on underrun hold the last sample instead of forcing silence.
module sdm_stream_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int OSR         = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [15:0]            s_data,
  output logic                          mod_tick,
  output logic                          adc_tick,
  output logic signed [15:0]            mod_sample,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int OW = $clog2(OSR);

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [OW-1:0] OSR_MAX = OW'(OSR - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } state_t;

  state_t             st;
  logic signed [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [DW-1:0]      div_cnt;
  logic [OW-1:0]      osr_cnt;

  logic               run_like;
  logic               push;
  logic               pop;
  logic               tick_now;
  logic               bnd_now;
  logic [LW-1:0]      level_n;

  assign state = st;

  // The boundary decision (pop vs underrun) is taken on the tick-generating edge using the
  // registered level; the resulting pop lands one cycle later, while sample_tick is high.
  always_comb begin
    run_like = (st == RUN) || (st == UNDERRUN);
    push     = s_valid && s_ready;
    pop      = ((st == PRIME) && (fifo_level >= PRIME_L)) ||
               (run_like && sample_tick && !underrun);
    level_n  = fifo_level + LW'(push) - LW'(pop);
    tick_now = run_like && (div_cnt == DIV_MAX);
    bnd_now  = tick_now && (osr_cnt == OSR_MAX);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      st          <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      div_cnt     <= '0;
      osr_cnt     <= '0;
      mod_sample  <= '0;
      s_ready     <= 1'b0;
      mod_tick    <= 1'b0;
      adc_tick    <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      mod_tick    <= 1'b0;
      adc_tick    <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      fifo_level  <= level_n;
      s_ready     <= (level_n < DEPTH_L);

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        mod_sample <= mem[rd_ptr];
      end

      case (st)
        IDLE: st <= PRIME;

        PRIME: begin
          if (pop) begin
            st      <= RUN;
            div_cnt <= '0;
            osr_cnt <= '0;
          end
        end

        RUN, UNDERRUN: begin
          div_cnt  <= tick_now ? '0 : div_cnt + DW'(1);
          mod_tick <= tick_now;
          adc_tick <= tick_now;
          if (tick_now) osr_cnt <= bnd_now ? '0 : osr_cnt + OW'(1);
          sample_tick <= bnd_now;
          underrun    <= bnd_now && (fifo_level == '0);

          if (sample_tick) begin
            if (underrun) begin
              st <= UNDERRUN;
`ifdef SDM_UNDERRUN_HOLD_EN
              mod_sample <= mod_sample;
`else
              mod_sample <= '0;
`endif
            end else begin
              st <= RUN;
            end
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule
